// File: rtl/descrambler_lfsr_5.sv
// ============================================================================
// Module   : descrambler_lfsr_5
// Brief    : 43-bit Galois LFSR descrambler with training/lock state machine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module descrambler_lfsr_5 #(
  parameter int POLY_WIDTH   = 43,
  parameter int NUM_OF_STEPS = 15,
  parameter int TRAIN_WORDS  = 16,
  parameter int ERR_THRESH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write,
  input  logic [11:0]             addr,
  input  logic [31:0]             lfsrdin,
  input  logic                    din_valid,
  input  logic [NUM_OF_STEPS-1:0] din,
  output logic [NUM_OF_STEPS-1:0] dout,
  output logic                    dout_valid,
  output logic                    lock,
  output logic                    train_fail,
  output logic [7:0]              err_cnt,
  output logic [POLY_WIDTH-1:0]   lfsr_state
);

  localparam int CNT_W = $clog2(TRAIN_WORDS + 1);

  localparam logic [11:0] C_ADDR_SEED_LO = 12'h0b4;
  localparam logic [11:0] C_ADDR_SEED_HI = 12'h0b5;
  localparam logic [11:0] C_ADDR_CTRL    = 12'h0b6;

  // Feedback mask: bit 0 plus the XOR taps at 8, 25, 30, 32, 35.
  localparam logic [POLY_WIDTH-1:0] C_TAPS      = 43'h9_4200_0101;
  localparam logic [CNT_W-1:0]      C_TRAIN_CNT = CNT_W'(TRAIN_WORDS);
  localparam logic [7:0]            C_ERR_THR   = 8'(ERR_THRESH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRAIN  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [POLY_WIDTH-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              err_q, err_d;
  logic                    fail_q, fail_d;
  logic                    lock_q;
  logic                    dvalid_q, dvalid_d;
  logic [NUM_OF_STEPS-1:0] dout_q, dout_d;

  logic                    w_seed_wr;
  logic                    w_ctrl_wr;
  logic                    w_advance;
  logic                    w_last_word;
  logic [NUM_OF_STEPS-1:0] w_plain;
  logic [7:0]              w_err_inc;

  function automatic logic [POLY_WIDTH-1:0] f_word_step(input logic [POLY_WIDTH-1:0] s);
    logic [POLY_WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < NUM_OF_STEPS; i++) begin
      v = {v[POLY_WIDTH-2:0], 1'b0} ^ ({POLY_WIDTH{v[POLY_WIDTH-1]}} & C_TAPS);
    end
    return v;
  endfunction

  assign w_seed_wr   = write && ((addr == C_ADDR_SEED_LO) || (addr == C_ADDR_SEED_HI));
  assign w_ctrl_wr   = write && (addr == C_ADDR_CTRL);
  // A seed write in the same cycle drops the incoming word entirely.
  assign w_advance   = din_valid && !w_seed_wr && ((state_q == S_TRAIN) || (state_q == S_LOCKED));
  assign w_plain     = din ^ lfsr_q[POLY_WIDTH-1 -: NUM_OF_STEPS];
  assign w_err_inc   = ((|w_plain) && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  assign w_last_word = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_seed_wr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (w_ctrl_wr && lfsrdin[0]) state_d = S_TRAIN;
        S_TRAIN:  if (w_advance && w_last_word)
                    state_d = (w_err_inc <= C_ERR_THR) ? S_LOCKED : S_IDLE;
        S_LOCKED: state_d = S_LOCKED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fail_d   = fail_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (w_seed_wr) begin
      if (addr == C_ADDR_SEED_LO) lfsr_d[31:0] = lfsrdin;
      else                        lfsr_d[POLY_WIDTH-1:32] = lfsrdin[POLY_WIDTH-33:0];
    end else if (w_advance) begin
      lfsr_d = f_word_step(lfsr_q);
      dout_d = w_plain;
      if (state_q == S_TRAIN) begin
        err_d = w_err_inc;
        cnt_d = cnt_q - CNT_W'(1);
        if (w_last_word && (w_err_inc > C_ERR_THR)) fail_d = 1'b1;
      end else begin
        dvalid_d = 1'b1;
      end
    end
    if (w_ctrl_wr && (state_q == S_IDLE) && lfsrdin[0]) begin
      cnt_d = C_TRAIN_CNT;
      err_d = 8'd0;
    end
    if (w_ctrl_wr && lfsrdin[1]) begin
      fail_d = 1'b0;
      err_d  = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      fail_q   <= 1'b0;
      lock_q   <= 1'b0;
      dvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      lock_q   <= (state_d == S_LOCKED);
      dvalid_q <= dvalid_d;
      dout_q   <= dout_d;
    end
  end

  always_comb begin
    dout       = dout_q;
    dout_valid = dvalid_q;
    lock       = lock_q;
    train_fail = fail_q;
    err_cnt    = err_q;
    lfsr_state = lfsr_q;
  end

endmodule

`default_nettype wire

// File: doc/descrambler_lfsr_5.md
Name: descrambler_lfsr_5

Overview:
- Receive-side counterpart of the 43-bit, 15-step primary scrambler LFSR.
- Holds an identical Galois LFSR, seeded over the same register bus, and XORs each received 15-bit word with the same keystream to recover plaintext.
- A training state machine checks an all-zero training sequence, counts mismatches, and declares lock before payload passes downstream.

Parameters:
- POLY_WIDTH, 43, LFSR width. Fixed by the polynomial and not changeable in practice.
- NUM_OF_STEPS, 15, LFSR single-steps per received word. Also the data word width.
- TRAIN_WORDS, 16, number of training words checked in TRAIN.
- ERR_THRESH, 2, maximum training mismatches that still allow lock.

Ports:
- clk  input  1  clock. Single clock domain.
- rst  input  1  reset. Asynchronous, active-high.
- write  input  1  register write strobe.
- addr  input  12  register address.
- lfsrdin  input  32  register write data.
- din_valid  input  1  a received scrambled word is present on din this cycle.
- din  input  15  scrambled word.
- dout  output  15  descrambled word, registered.
- dout_valid  output  1  dout holds payload (LOCKED state only).
- lock  output  1  high in LOCKED.
- train_fail  output  1  sticky; set when training ends with too many mismatches.
- err_cnt  output  8  training mismatch count, saturating at 255.
- lfsr_state  output  43  current LFSR register, for debug and verification.

Behaviour:
- Reset (async, rst=1): every output and internal register is 0. The LFSR is 43'h0 and the state is IDLE.
- One LFSR single-step, with s = current state:
  - n[0] = s[42].
  - n[k] = s[k-1] ^ s[42] for k in {8, 25, 30, 32, 35}.
  - n[k] = s[k-1] for all other k in 1..42.
- Word step: 15 chained single-steps, computed combinationally in one cycle.
- Keystream for a word is lfsr_state[42:28], taken before that word's advance.
- Register map:
  - 0x0b4: seed bits [31:0].
  - 0x0b5: seed bits [42:32], taken from lfsrdin[10:0].
  - 0x0b6: control. lfsrdin[0]=1 starts training; lfsrdin[1]=1 clears train_fail and err_cnt.
- A seed write (0x0b4 or 0x0b5) in any state:
  - loads the addressed bits and forces IDLE;
  - clears lock and dout_valid the next cycle;
  - takes priority over din_valid in the same cycle, so that word is dropped and the LFSR does not advance.
- FSM states: IDLE, TRAIN, LOCKED.
  - IDLE: the LFSR holds and din is ignored.
    - A control write with bit0=1 goes to TRAIN, loads train counter = TRAIN_WORDS and clears err_cnt.
    - A control write in any other state is ignored except for the bit1 clear.
  - TRAIN: on each din_valid, the LFSR advances one word step.
    - If (din ^ keystream) != 0, err_cnt increments.
    - The train counter decrements.
    - On the word that brings the counter to 0, the next state is chosen with the final err_cnt including that word:
      - err_cnt <= ERR_THRESH goes to LOCKED;
      - otherwise it goes to IDLE and sets train_fail.
  - LOCKED: on each din_valid, the LFSR advances and dout <= din ^ keystream, with dout_valid=1 the next cycle.
    - Cycles without din_valid give dout_valid=0; dout holds its last value.
- Latency: 1 clock from din_valid to dout/dout_valid.
  - dout also updates during TRAIN for observability, but dout_valid stays 0.
- lock = (state == LOCKED), registered.
- An all-zero seed is legal: the LFSR stays 0 and the keystream is 0.
- Reset asserted mid-operation aborts immediately to the reset values. The seed is lost.
- An LFSR advance only occurs on din_valid in TRAIN or LOCKED. It is never gated by a delayed enable.

Test Plan:
- Reset, then write 0x0b4=1, 0x0b5=0 → lfsr_state=43'h1.
  - Control start, then 1 word → lfsr_state=43'h8000.
  - 2nd word → 43'h4000_0000.
- Seed 43'h400_0000_0000, TRAIN, one din=15'h4000 → err_cnt stays 0.
  - The keystream of that word is 0x4000.
- Loopback against the scrambler: both sides get the same seed 43'h1234_5678_9AB.
  - Send 16 zero training words, then 100 random payload words through the transmit LFSR.
  - Required: lock=1 after word 16, dout matches payload bit-exactly, and err_cnt=0.
- Corrupt 3 training words with din ^= 15'h0001 (ERR_THRESH=2).
  - After the 16th word: state IDLE, train_fail=1, err_cnt=3, lock=0.
  - Then a control write of 0x2 → train_fail=0, err_cnt=0.
- Seed write in the same cycle as din_valid while LOCKED.
  - lfsr_state equals the new seed, with no advance.
  - lock=0 and dout_valid=0 the next cycle.
- Assert rst mid-TRAIN with counter=7 → all outputs 0 asynchronously, and state IDLE after deassertion.
